// File: rtl/apb_master_bridge.sv
// Purpose: APB requester turning a valid/ready command into one IDLE->SETUP->ACCESS transfer plus a response.
// Latency: response pulse 2 edges after accept with zero wait states, +1 cycle per wait state; 1 transfer / 3 cycles.
// Backpressure: cmd_ready only in IDLE (no queuing); rsp_valid is a single-cycle pulse with no backpressure.
//
// Ports:
//   pclk, presetn                    clock (rising edge) and asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake; cmd_write/cmd_addr/cmd_wdata describe the transfer
//   rsp_valid/rsp_rdata/rsp_err      registered response; rdata/err hold until the next completion
//   psel/penable/pwrite/paddr/pwdata registered APB requester outputs
//   prdata/pready/pslverr            APB completer inputs, sampled only at an ACCESS edge with pready=1
module apb_master_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]      wait_inc;
  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  rsp_valid_d, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  assign cmd_ready = (state_q == IDLE);
  assign wait_inc  = wait_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          paddr_d    = cmd_addr;
          pwrite_d   = cmd_write;
          pwdata_d   = cmd_write ? cmd_wdata : '0;
          psel_d     = 1'b1;
          wait_cnt_d = '0;
          state_d    = SETUP;
        end
      end

      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite ? '0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_inc;
          // Abort on the TIMEOUT-th consecutive wait cycle; the response
          // looks like a normal completion but flags an error.
          if ((TIMEOUT != 0) && (wait_inc == TIMEOUT_CNT)) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        // Unused encoding: drop the bus and fall back to IDLE.
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      psel       <= psel_d;
      penable    <= penable_d;
      pwrite     <= pwrite_d;
      paddr      <= paddr_d;
      pwdata     <= pwdata_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose: directed bench for apb_master_bridge with a response scoreboard.
// Latency: checks the exact cycle of SETUP, ACCESS and the response pulse for every command.
// Backpressure: drives busy-time commands that must be ignored; responses are popped as they appear.
module tb_apb_master_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          pclk;
  logic          presetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_rdata_q[$];
  logic          exp_err_q[$];
  logic [DW-1:0] last_rdata;
  logic          last_err;

  apb_master_bridge #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding command.
  always @(negedge pclk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_rdata_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        chk("rsp_rdata", rsp_rdata, exp_rdata_q.pop_front());
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One complete transfer, entered and left at a negedge with the DUT in IDLE.
  // nwait >= TO means pready is never raised and the timeout must fire.
  // hold_valid keeps cmd_valid high with junk while busy; it must be ignored.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int nwait, input logic [DW-1:0] rdata, input logic slverr,
                         input logic hold_valid);
    logic          tmo;
    logic [DW-1:0] e_rdata;
    logic          e_err;
    int            n_acc;
    tmo     = (nwait >= TO);
    e_rdata = (tmo || wr) ? '0 : rdata;
    e_err   = tmo ? 1'b1 : slverr;
    n_acc   = tmo ? TO : nwait + 1;

    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    exp_rdata_q.push_back(e_rdata);
    exp_err_q.push_back(e_err);

    // SETUP cycle
    @(negedge pclk);
    cmd_valid = hold_valid;
    cmd_write = ~wr;
    cmd_addr  = addr ^ 32'hFFFF_0000;
    cmd_wdata = ~wdata;
    chk("setup_psel", {31'd0, psel}, 32'd1);
    chk("setup_penable", {31'd0, penable}, 32'd0);
    chk("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("setup_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("setup_pwrite", {31'd0, pwrite}, {31'd0, wr});
    chk("setup_paddr", paddr, addr);
    chk("setup_pwdata", pwdata, wr ? wdata : 32'd0);
    chk("hold_rsp_rdata", rsp_rdata, last_rdata);
    chk("hold_rsp_err", {31'd0, rsp_err}, {31'd0, last_err});
    // pready/pslverr during SETUP must not complete or leak into the response
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hBAD0_5E70;

    for (int i = 0; i < n_acc; i++) begin
      @(negedge pclk);
      chk("access_psel", {31'd0, psel}, 32'd1);
      chk("access_penable", {31'd0, penable}, 32'd1);
      chk("access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("access_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("access_paddr", paddr, addr);
      chk("access_pwrite", {31'd0, pwrite}, {31'd0, wr});
      chk("access_pwdata", pwdata, wr ? wdata : 32'd0);
      if (tmo || i < n_acc - 1) begin
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'hBAD0_0000 + 32'(i);
      end else begin
        pready  = 1'b1;
        pslverr = slverr;
        prdata  = rdata;
      end
    end

    // Response cycle: bus idle, ready for the next command
    @(negedge pclk);
    cmd_valid = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 32'h0;
    chk("rsp_cycle_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_cycle_psel", {31'd0, psel}, 32'd0);
    chk("rsp_cycle_penable", {31'd0, penable}, 32'd0);
    chk("rsp_cycle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    last_rdata = e_rdata;
    last_err   = e_err;
  endtask

  initial begin
    presetn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    prdata     = '0;
    pready     = 1'b0;
    pslverr    = 1'b0;
    last_rdata = '0;
    last_err   = 1'b0;

    // Reset values
    repeat (3) @(negedge pclk);
    chk("rst_psel", {31'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_psel", {31'd0, psel}, 32'd0);

    // Write, zero waits
    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b0);
    @(negedge pclk);
    chk("pulse_single", {31'd0, rsp_valid}, 32'd0);
    // Read with two wait states
    do_xfer(1'b0, 32'h20, 32'h0, 2, 32'h12345678, 1'b0, 1'b0);
    @(negedge pclk);
    // Read with slave error, then a write accepted in the response cycle
    do_xfer(1'b0, 32'h30, 32'h0, 1, 32'hCAFEF00D, 1'b1, 1'b0);
    do_xfer(1'b1, 32'h34, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 1'b0);
    // Write with slave error
    do_xfer(1'b1, 32'h38, 32'h01020304, 0, 32'hFFFFFFFF, 1'b1, 1'b0);
    // Longest wait that still completes normally
    do_xfer(1'b0, 32'h3C, 32'h0, TO - 1, 32'h0BADCAFE, 1'b0, 1'b0);
    // Timeouts, read then write
    do_xfer(1'b0, 32'h40, 32'h0, TO, 32'h0, 1'b0, 1'b0);
    @(negedge pclk);
    do_xfer(1'b1, 32'h44, 32'h55AA55AA, TO, 32'h0, 1'b0, 1'b0);
    // Back-to-back with cmd_valid held high throughout
    do_xfer(1'b1, 32'h100, 32'h11111111, 0, 32'h0, 1'b0, 1'b1);
    do_xfer(1'b0, 32'h104, 32'h0, 0, 32'h76543210, 1'b0, 1'b1);
    do_xfer(1'b1, 32'h108, 32'h33333333, 0, 32'h0, 1'b1, 1'b1);
    @(negedge pclk);
    chk("b2b_no_extra_accept", {31'd0, cmd_ready}, 32'd1);

    // Reset in ACCESS: no response for the aborted command
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h200;
    @(negedge pclk);
    cmd_valid = 1'b0;
    pready    = 1'b0;
    @(negedge pclk);
    chk("abort_in_access", {31'd0, penable}, 32'd1);
    #2;
    presetn = 1'b0;
    #1;
    chk("abort_psel", {31'd0, psel}, 32'd0);
    chk("abort_penable", {31'd0, penable}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(negedge pclk);
    presetn    = 1'b1;
    last_rdata = '0;
    last_err   = 1'b0;
    @(negedge pclk);
    chk("abort_post_ready", {31'd0, cmd_ready}, 32'd1);
    do_xfer(1'b0, 32'h204, 32'h0, 1, 32'hFEEDFACE, 1'b0, 1'b0);

    repeat (3) @(negedge pclk);
    chk("scoreboard_empty", 32'(exp_rdata_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
